// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard controller: tracks in-flight destinations and Tnew,
// and derives the D-stage stall, rs/rt forwarding selects and the mult/div busy interval.
module hazard_stall_ctrl #(
    parameter int STAGES      = 3,
    parameter int TNEW_W      = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int SEL_W       = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [4:0]        d_rs_addr,
    input  logic [4:0]        d_rt_addr,
    input  logic [TNEW_W-1:0] d_rs_tuse,
    input  logic [TNEW_W-1:0] d_rt_tuse,
    input  logic [4:0]        d_dst_addr,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic [1:0]        d_md_op,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              md_busy
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic              valid_q [1:STAGES];
    logic [4:0]        dst_q   [1:STAGES];
    logic [TNEW_W-1:0] tnew_q  [1:STAGES];
    logic [MD_W-1:0]   md_cnt;

    logic              rs_hit, rt_hit;
    logic [TNEW_W-1:0] rs_tnew, rt_tnew;
    logic [SEL_W-1:0]  rs_k, rt_k;
    logic              data_stall, md_stall, issue;

    // Walk from the oldest entry to the youngest so the nearest match is the one left standing.
    always_comb begin
        rs_hit  = 1'b0;
        rs_tnew = '0;
        rs_k    = '0;
        rt_hit  = 1'b0;
        rt_tnew = '0;
        rt_k    = '0;
        if (d_rs_tuse != '1 && d_rs_addr != 5'd0) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (valid_q[k] && dst_q[k] == d_rs_addr) begin
                    rs_hit  = 1'b1;
                    rs_tnew = tnew_q[k];
                    rs_k    = SEL_W'(k);
                end
            end
        end
        if (d_rt_tuse != '1 && d_rt_addr != 5'd0) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (valid_q[k] && dst_q[k] == d_rt_addr) begin
                    rt_hit  = 1'b1;
                    rt_tnew = tnew_q[k];
                    rt_k    = SEL_W'(k);
                end
            end
        end
    end

    assign data_stall = d_valid && ((rs_hit && rs_tnew > d_rs_tuse) ||
                                    (rt_hit && rt_tnew > d_rt_tuse));
    assign md_busy    = (md_cnt != '0);
    assign md_stall   = d_valid && (d_md_op != 2'b00) && md_busy;
    assign stall      = data_stall || md_stall;
    assign issue      = d_valid && !stall;
    assign fwd_rs_sel = (rs_hit && rs_tnew == '0) ? rs_k : '0;
    assign fwd_rt_sel = (rt_hit && rt_tnew == '0) ? rt_k : '0;

    // A stalled or empty D slot enters entry 1 as a bubble; older entries age by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++) begin
                valid_q[k] <= 1'b0;
                dst_q[k]   <= 5'd0;
                tnew_q[k]  <= '0;
            end
        end else begin
            valid_q[1] <= issue;
            dst_q[1]   <= issue ? d_dst_addr : 5'd0;
            tnew_q[1]  <= issue ? d_tnew : '0;
            for (int k = 2; k <= STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                dst_q[k]   <= dst_q[k-1];
                tnew_q[k]  <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TNEW_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (issue && d_md_op == 2'b01) begin
            md_cnt <= MD_W'(MULT_CYCLES);
        end else if (issue && d_md_op == 2'b10) begin
            md_cnt <= MD_W'(DIV_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboarded bench for hazard_stall_ctrl: each driven D-stage word queues its expected
// stall/select/busy result, which is popped and compared once the outputs have settled.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs_addr, d_rt_addr, d_dst_addr;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew, d_md_op;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [1:0] rs_tuse;
        logic [4:0] rt;
        logic [1:0] rt_tuse;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [1:0] md;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] rs_sel;
        logic [1:0] rt_sel;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    hazard_stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs_addr  (d_rs_addr),
        .d_rt_addr  (d_rt_addr),
        .d_rs_tuse  (d_rs_tuse),
        .d_rt_tuse  (d_rt_tuse),
        .d_dst_addr (d_dst_addr),
        .d_tnew     (d_tnew),
        .d_md_op    (d_md_op),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic v, input logic [4:0] rs, input logic [1:0] rs_tuse,
                                 input logic [4:0] rt, input logic [1:0] rt_tuse,
                                 input logic [4:0] dst, input logic [1:0] tnew, input logic [1:0] md);
        stim_t s;
        s.v = v; s.rs = rs; s.rs_tuse = rs_tuse; s.rt = rt; s.rt_tuse = rt_tuse;
        s.dst = dst; s.tnew = tnew; s.md = md;
        return s;
    endfunction

    function automatic exp_t ex(input logic st, input logic [1:0] rs_sel,
                                input logic [1:0] rt_sel, input logic busy);
        exp_t e;
        e.stall = st; e.rs_sel = rs_sel; e.rt_sel = rt_sel; e.busy = busy;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic driveInputs(input stim_t s, input exp_t e);
        d_valid    = s.v;
        d_rs_addr  = s.rs;
        d_rs_tuse  = s.rs_tuse;
        d_rt_addr  = s.rt;
        d_rt_tuse  = s.rt_tuse;
        d_dst_addr = s.dst;
        d_tnew     = s.tnew;
        d_md_op    = s.md;
        exp_q.push_back(e);
    endtask

    task automatic sampleOutput(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            checkOutput({name, ".queue_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        checkOutput({name, ".stall"},   int'(stall),      int'(e.stall));
        checkOutput({name, ".rs_sel"},  int'(fwd_rs_sel), int'(e.rs_sel));
        checkOutput({name, ".rt_sel"},  int'(fwd_rt_sel), int'(e.rt_sel));
        checkOutput({name, ".md_busy"}, int'(md_busy),    int'(e.busy));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic applyStimulus(input string name, input stim_t s, input exp_t e);
        driveInputs(s, e);
        @(negedge clk);
        sampleOutput(name);
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input string name, input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(name, '0, ex(0, 0, 0, 0));
    endtask

    initial begin
        reset = 1'b1;
        driveInputs(mk(1, 1, 0, 2, 0, 3, 2, 2'b11), ex(0, 0, 0, 0));
        #2;
        sampleOutput("reset_state");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // load-use: one bubble, consumer issues with producer in M and no forward
        applyStimulus("lu_lw",   mk(1, 2, 1, 0, 3, 1, 2, 0), ex(0, 0, 0, 0));
        applyStimulus("lu_add0", mk(1, 1, 1, 3, 1, 2, 1, 0), ex(1, 0, 0, 0));
        applyStimulus("lu_add1", mk(1, 1, 1, 3, 1, 2, 1, 0), ex(0, 0, 0, 0));
        flush("lu_nop", 3);

        // load-branch: two stalls, then forward from W
        applyStimulus("lb_lw",   mk(1, 0, 1, 0, 3, 4, 2, 0), ex(0, 0, 0, 0));
        applyStimulus("lb_beq0", mk(1, 4, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 0));
        applyStimulus("lb_beq1", mk(1, 4, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 0));
        applyStimulus("lb_beq2", mk(1, 4, 0, 0, 0, 0, 0, 0), ex(0, 3, 0, 0));
        flush("lb_nop", 3);

        // nearest match: the younger addu governs, not the older ori
        applyStimulus("nm_ori",  mk(1, 0, 1, 0, 3, 5, 1, 0), ex(0, 0, 0, 0));
        applyStimulus("nm_addu", mk(1, 6, 1, 7, 1, 5, 1, 0), ex(0, 0, 0, 0));
        applyStimulus("nm_beq0", mk(1, 5, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 0));
        applyStimulus("nm_beq1", mk(1, 5, 0, 0, 0, 0, 0, 0), ex(0, 2, 0, 0));
        flush("nm_nop", 3);

        // $0 never matches; an unused operand never matches
        applyStimulus("z_lw0",   mk(1, 0, 1, 0, 3, 0, 2, 0), ex(0, 0, 0, 0));
        applyStimulus("z_beq",   mk(1, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0));
        applyStimulus("u_lw8",   mk(1, 0, 1, 0, 3, 8, 2, 0), ex(0, 0, 0, 0));
        applyStimulus("u_rt8",   mk(1, 9, 1, 8, 3, 10, 1, 0), ex(0, 0, 0, 0));
        flush("zu_nop", 3);

        // rt path: ALU producer, tuse-0 consumer on rt
        applyStimulus("rt_alu",  mk(1, 0, 1, 0, 1, 11, 1, 0), ex(0, 0, 0, 0));
        applyStimulus("rt_bne0", mk(1, 0, 0, 11, 0, 0, 0, 0), ex(1, 0, 0, 0));
        applyStimulus("rt_bne1", mk(1, 0, 0, 11, 0, 0, 0, 0), ex(0, 0, 2, 0));
        flush("rt_nop", 3);

        // mult then mflo: exactly MULT_CYCLES stall cycles
        applyStimulus("mu_mult", mk(1, 2, 1, 3, 1, 0, 0, 2'b01), ex(0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            applyStimulus($sformatf("mu_mflo_stall%0d", i), mk(1, 0, 3, 0, 3, 12, 1, 2'b11), ex(1, 0, 0, 1));
        applyStimulus("mu_mflo_go", mk(1, 0, 3, 0, 3, 12, 1, 2'b11), ex(0, 0, 0, 0));
        flush("mu_nop", 3);

        // div then mfhi: DIV_CYCLES stall cycles
        applyStimulus("dv_div",  mk(1, 2, 1, 3, 1, 0, 0, 2'b10), ex(0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            applyStimulus($sformatf("dv_mfhi_stall%0d", i), mk(1, 0, 3, 0, 3, 12, 1, 2'b11), ex(1, 0, 0, 1));
        applyStimulus("dv_mfhi_go", mk(1, 0, 3, 0, 3, 12, 1, 2'b11), ex(0, 0, 0, 0));
        flush("dv_nop", 3);

        // idle D slots still count the busy interval down
        applyStimulus("id_mult", mk(1, 2, 1, 3, 1, 0, 0, 2'b01), ex(0, 0, 0, 0));
        applyStimulus("id_idle0", mk(0, 0, 0, 0, 0, 0, 0, 2'b11), ex(0, 0, 0, 1));
        applyStimulus("id_idle1", mk(0, 0, 0, 0, 0, 0, 0, 2'b11), ex(0, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("id_mflo_stall%0d", i), mk(1, 0, 3, 0, 3, 12, 1, 2'b11), ex(1, 0, 0, 1));
        applyStimulus("id_mflo_go", mk(1, 0, 3, 0, 3, 12, 1, 2'b11), ex(0, 0, 0, 0));
        flush("id_nop", 3);

        // reset mid-div with a load in E: everything clears immediately
        applyStimulus("rs_div", mk(1, 2, 1, 3, 1, 0, 0, 2'b10), ex(0, 0, 0, 0));
        applyStimulus("rs_lw",  mk(1, 0, 1, 0, 3, 13, 2, 0), ex(0, 0, 0, 1));
        driveInputs(mk(1, 13, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 1));
        @(negedge clk);
        sampleOutput("rs_beq_pre");
        reset = 1'b1;
        exp_q.push_back(ex(0, 0, 0, 0));
        #1;
        sampleOutput("rs_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus("rs_mfhi", mk(1, 0, 3, 0, 3, 14, 1, 2'b11), ex(0, 0, 0, 0));
        applyStimulus("rs_beq",  mk(1, 13, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0));
        flush("rs_nop", 2);

        if (exp_q.size() != 0)
            checkOutput("queue_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised decode-stage hazard controller for the pipelined MIPS core. It consumes the Tuse/Tnew classification that the D-stage decoder produces, and tracks destination register and remaining Tnew of every in-flight instruction across a configurable number of downstream stages. It also models the multiply/divide unit's busy interval. From this state it drives the D-stage stall/bubble signal and the D-stage forwarding selects for rs and rt.

## Interface
- `STAGES`, 3: tracked stages after D (1 = E, 2 = M, 3 = W); legal 2..7.
- `TNEW_W`, 2: width of Tuse/Tnew fields; Tuse value all-ones means "operand unused".
- `MULT_CYCLES`, 5: busy cycles after a mult-class issue; ≥1.
- `DIV_CYCLES`, 10: busy cycles after a div-class issue; ≥1.
- `SEL_W`, clog2(STAGES+1): forwarding select width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `d_valid`  in  1  D holds a real instruction.
- `d_rs_addr`, `d_rt_addr`  in  5  source register numbers.
- `d_rs_tuse`, `d_rt_tuse`  in  TNEW_W  cycles until the operand is consumed; all-ones = unused.
- `d_dst_addr`  in  5  destination register; 0 = no write.
- `d_tnew`  in  TNEW_W  Tnew on entry to E: 0 alu-less, 1 alu, 2 load.
- `d_md_op`  in  2  00 none, 01 mult-class, 10 div-class, 11 HI/LO access.
- `stall`  out  1  freeze PC and the D register, inject a bubble into E.
- `fwd_rs_sel`, `fwd_rt_sel`  out  SEL_W  0 = register file, k = stage k's result.
- `md_busy`  out  1  multiply/divide counter nonzero.

## Operation
- Tracker entry k (1..STAGES) holds {valid_k, dst_k, tnew_k}.
- Issue happens when `d_valid && !stall`.
- On each edge:
  - entry 1 ← issue ? {1, d_dst_addr, d_tnew} : {0, 0, 0};
  - entry k ← entry k-1 with tnew decremented, saturating at 0; the last entry is discarded.
- Match for operand rs (rt identical):
  - Search entries in order 1..STAGES for the smallest k with valid_k, dst_k == d_rs_addr, dst_k != 0.
  - Only this nearest match counts; farther matches are ignored.
  - Skip the search entirely when d_rs_tuse is all-ones or d_rs_addr == 0.
- Data stall occurs when a nearest match exists with tnew_k > d_rs_tuse (same rule for rt). It is gated by d_valid.
- Forward select:
  - fwd_rs_sel = k when the nearest match has tnew_k == 0; otherwise 0.
  - A match with 0 < tnew_k ≤ tuse gives sel 0 and no stall; a later stage resolves it.
- MD counter `md_cnt`:
  - Width holds max(MULT_CYCLES, DIV_CYCLES).
  - On issue with d_md_op 01: load MULT_CYCLES. With 10: load DIV_CYCLES.
  - Otherwise decrement when nonzero.
  - md_busy = (md_cnt != 0).
- MD stall = d_valid && d_md_op != 00 && md_busy. A new mult/div/HI-LO access waits until the counter reaches 0.
- stall = data stall || MD stall. It is purely combinational from tracker state and D inputs; no registered output.

## Timing
- Reset (async, immediate): all valid_k = 0, dst_k = 0, tnew_k = 0, md_cnt = 0. Outputs settle to stall = 0, fwd_*_sel = 0, md_busy = 0.
- Reset asserted mid-multiply clears md_cnt immediately. The first post-reset HI/LO access does not stall.
- Load (d_tnew = 2) followed by a consumer with tuse 1: exactly 1 stall cycle. The consumer issues with the producer in M (tnew 1); no D-stage forward.
- Load followed by a branch/jr reading it (tuse 0): 2 stall cycles. In the cycle it issues, the producer is in W with fwd_sel = 3 (STAGES = 3).
- ALU result (d_tnew = 1) with a tuse-0 consumer: 1 stall cycle, then fwd_sel = 2.
- Mult issued at edge t: md_cnt = MULT_CYCLES after t. A following HI/LO access stalls exactly MULT_CYCLES cycles. For DIV it stalls DIV_CYCLES cycles.
- A stall cycle inserts a bubble in entry 1. MD and data stalls may overlap; stall stays high until both conditions clear.
- d_valid = 0: no issue, stall = 0, md_cnt still decrements.

## Test plan
- Load-use: lw $1 then add $2,$1,$3 (rs_tuse 1) → stall high 1 cycle, add issues next cycle with fwd_rs_sel = 0.
- Load-branch: lw $4 then beq $4,$0 (tuse 0) → stall 2 cycles, then fwd_rs_sel = 3 for one cycle, stall 0.
- Nearest match: ori $5 (tnew 1) then addu $5 (tnew 1) then beq $5 → sel/stall follow the addu entry (1 stall, then sel = 2), not the older ori.
- $0 and unused: lw $0 followed by beq $0,$0, and an instruction with rt_tuse = 3 matching a pending lw on rt → stall 0, sel 0.
- MD busy: mult then mflo → md_busy high 5 cycles, stall 5 cycles; div then mfhi → 10 cycles.
- Async reset mid-op: assert reset 3 cycles into a div with a pending lw in E → all outputs 0 immediately; mfhi after release issues without stall.
